// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// The unit accepts one operation at a time and gives a one-cycle result-ready pulse.
module multdiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic signed [WIDTH-1:0] data_operandA,
   input  logic signed [WIDTH-1:0] data_operandB,
   input  logic                    ctrl_MULT,
   input  logic                    ctrl_DIV,
   output logic signed [WIDTH-1:0] data_result,
   output logic                    data_exception,
   output logic                    data_resultRDY,
   output logic                    busy
);

   localparam int ACC_W = 2*WIDTH + 1;
   localparam int REM_W = WIDTH + 1;
   localparam logic [5:0] LAST = 6'd32;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state;
   logic [5:0]        count;
   logic [ACC_W-1:0]  acc;
   logic signed [WIDTH-1:0] mcand;
   logic [REM_W-1:0]  rem;
   logic [WIDTH-1:0]  quo;
   logic [WIDTH-1:0]  dvs;
   logic              neg_q;
   logic              div_zero;

   logic              accept;
   logic              start_mul;
   logic [REM_W:0]    rem_sh;
   logic [REM_W:0]    rem_diff;
   logic [REM_W-1:0]  rem_nxt;
   logic [WIDTH-1:0]  quo_nxt;
   logic [2*WIDTH-1:0] product;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
   endfunction

   // One Booth step: add/subtract in 33 bits so the shifted-in sign survives
   // the -2^31 multiplicand case, then arithmetic-shift the whole accumulator.
   function automatic logic [ACC_W-1:0] booth_step(input logic [ACC_W-1:0] a,
                                                   input logic signed [WIDTH-1:0] m);
      logic signed [WIDTH:0] hi;
      logic signed [WIDTH:0] m_ext;
      logic [ACC_W:0]        wide;
      hi    = {a[ACC_W-1], a[ACC_W-1 -: WIDTH]};
      m_ext = {m[WIDTH-1], m};
      case (a[1:0])
         2'b01:   hi = hi + m_ext;
         2'b10:   hi = hi - m_ext;
         default: hi = hi;
      endcase
      wide = {hi, a[WIDTH:0]};
      return wide[ACC_W:1];
   endfunction

   function automatic logic mul_overflow(input logic [2*WIDTH-1:0] p);
      return (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
             (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
   endfunction

   function automatic logic [WIDTH-1:0] div_apply_sign(input logic [WIDTH-1:0] q,
                                                       input logic neg);
      return neg ? (~q + WIDTH'(1)) : q;
   endfunction

   // A positive quotient of magnitude 2^31 only arises from -2^31 / -1.
   function automatic logic div_overflow(input logic [WIDTH-1:0] q, input logic neg);
      return q[WIDTH-1] & ~neg;
   endfunction

   always_comb begin
      accept    = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
      start_mul = ctrl_MULT;
      rem_sh    = {rem, quo[WIDTH-1]};
      rem_diff  = rem_sh - {2'b00, dvs};
      rem_nxt   = rem_diff[REM_W] ? rem_sh[REM_W-1:0] : rem_diff[REM_W-1:0];
      quo_nxt   = {quo[WIDTH-2:0], ~rem_diff[REM_W]};
      product   = acc[ACC_W-1:1];
   end

   // Datapath registers: loaded on acceptance, stepped while iterating.
   always_ff @(posedge clock) begin
      if (accept) begin
         mcand    <= data_operandA;
         acc      <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
         rem      <= '0;
         quo      <= magnitude(data_operandA);
         dvs      <= magnitude(data_operandB);
         neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero <= (data_operandB == '0);
      end else if ((state == MUL) && (count != LAST)) begin
         acc <= booth_step(acc, mcand);
      end else if ((state == DIV) && (count != LAST)) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         count          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state <= start_mul ? MUL : DIV;
                  count <= '0;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            MUL: begin
               if (count == LAST) begin
                  state          <= DONE;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  data_result    <= product[WIDTH-1:0];
                  data_exception <= mul_overflow(product);
               end else begin
                  count <= count + 6'd1;
               end
            end
            DIV: begin
               if (div_zero) begin
                  state          <= DONE;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  data_result    <= '0;
                  data_exception <= 1'b1;
               end else if (count == LAST) begin
                  state          <= DONE;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  data_result    <= div_apply_sign(quo, neg_q);
                  data_exception <= div_overflow(quo, neg_q);
               end else begin
                  count <= count + 6'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl: multiply, divide, divide-by-zero,
// start priority, back-to-back starts and asynchronous reset abort.
module tb_multdiv_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   multdiv_ctrl #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   // Called at a negedge; returns at the negedge after the accepting edge,
   // with operands scrambled so the result must come from latched copies.
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = ~a;
      data_operandB = b ^ 32'h5A5A_0001;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
         failures++;
         $display("FAIL reset_async: got result=%h exc=%b rdy=%b busy=%b, want all zero",
                  data_result, data_exception, data_resultRDY, busy);
      end
      repeat (2) @(negedge clock);
      checks++;
      if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
         failures++;
         $display("FAIL reset_held: got result=%h exc=%b rdy=%b busy=%b, want all zero",
                  data_result, data_exception, data_resultRDY, busy);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic [31:0] vr [7];
      logic        ve [7];
      va = '{32'd7, 32'd12345, 32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000, -32'sd65536};
      vb = '{-32'sd6, -32'sd6789, 32'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_8000};
      vr = '{32'hFFFF_FFD6, -32'sd83810205, 32'h0, 32'h0, 32'h1, 32'h8000_0000, 32'h8000_0000};
      ve = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         issue(1'b1, 1'b0, va[i], vb[i]);
         checks++;
         if ({busy, data_resultRDY} !== 2'b10) begin
            failures++;
            $display("FAIL mul_start[%0d]: got busy=%b rdy=%b, want busy=1 rdy=0", i, busy, data_resultRDY);
         end
         repeat (32) @(negedge clock);
         checks++;
         if ({busy, data_resultRDY} !== 2'b10) begin
            failures++;
            $display("FAIL mul_edge32[%0d]: got busy=%b rdy=%b, want busy=1 rdy=0", i, busy, data_resultRDY);
         end
         @(negedge clock);
         checks++;
         if ({data_resultRDY, busy, data_exception, data_result} !== {1'b1, 1'b0, ve[i], vr[i]}) begin
            failures++;
            $display("FAIL mul_result[%0d]: got rdy=%b busy=%b exc=%b result=%h, want rdy=1 busy=0 exc=%b result=%h",
                     i, data_resultRDY, busy, data_exception, data_result, ve[i], vr[i]);
         end
         @(negedge clock);
         checks++;
         if ({data_resultRDY, busy} !== 2'b00) begin
            failures++;
            $display("FAIL mul_rdy_drop[%0d]: got rdy=%b busy=%b, want rdy=0 busy=0", i, data_resultRDY, busy);
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic [31:0] vr [7];
      logic        ve [7];
      va = '{-32'sd7, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd3, 32'h7FFF_FFFF};
      vb = '{32'd2, -32'sd7, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd5, -32'sd2};
      vr = '{32'hFFFF_FFFD, -32'sd14, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -32'sd1073741823};
      ve = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         issue(1'b0, 1'b1, va[i], vb[i]);
         for (int k = 1; k <= 32; k++) begin
            if (i == 0 && k == 11) begin
               ctrl_MULT     = 1'b1;
               data_operandA = 32'd9;
               data_operandB = 32'd9;
            end
            @(negedge clock);
            ctrl_MULT = 1'b0;
            if (i == 0 && k == 11) begin
               checks++;
               if ({busy, data_resultRDY} !== 2'b10) begin
                  failures++;
                  $display("FAIL div_ignore_mult: got busy=%b rdy=%b, want busy=1 rdy=0", busy, data_resultRDY);
               end
            end
         end
         checks++;
         if ({busy, data_resultRDY} !== 2'b10) begin
            failures++;
            $display("FAIL div_edge32[%0d]: got busy=%b rdy=%b, want busy=1 rdy=0", i, busy, data_resultRDY);
         end
         @(negedge clock);
         checks++;
         if ({data_resultRDY, busy, data_exception, data_result} !== {1'b1, 1'b0, ve[i], vr[i]}) begin
            failures++;
            $display("FAIL div_result[%0d]: got rdy=%b busy=%b exc=%b result=%h, want rdy=1 busy=0 exc=%b result=%h",
                     i, data_resultRDY, busy, data_exception, data_result, ve[i], vr[i]);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_div_zero();
      issue(1'b0, 1'b1, 32'd5, 32'd0);
      checks++;
      if (data_resultRDY !== 1'b0) begin
         failures++;
         $display("FAIL divzero_accept: got rdy=%b, want rdy=0", data_resultRDY);
      end
      @(negedge clock);
      checks++;
      if ({data_resultRDY, busy, data_exception, data_result} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
         failures++;
         $display("FAIL divzero_result: got rdy=%b busy=%b exc=%b result=%h, want rdy=1 busy=0 exc=1 result=00000000",
                  data_resultRDY, busy, data_exception, data_result);
      end
      @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0) begin
         failures++;
         $display("FAIL divzero_rdy_drop: got rdy=%b, want rdy=0", data_resultRDY);
      end
   endtask

   task automatic test_both();
      issue(1'b1, 1'b1, 32'd3, 32'd3);
      repeat (33) @(negedge clock);
      checks++;
      if ({data_resultRDY, data_exception, data_result} !== {1'b1, 1'b0, 32'd9}) begin
         failures++;
         $display("FAIL both_starts: got rdy=%b exc=%b result=%h, want rdy=1 exc=0 result=00000009",
                  data_resultRDY, data_exception, data_result);
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (33) @(negedge clock);
      checks++;
      if ({data_resultRDY, data_exception, data_result} !== {1'b1, 1'b1, 32'h8000_0000}) begin
         failures++;
         $display("FAIL b2b_first: got rdy=%b exc=%b result=%h, want rdy=1 exc=1 result=80000000",
                  data_resultRDY, data_exception, data_result);
      end
      issue(1'b0, 1'b1, 32'd100, -32'sd7);
      checks++;
      if ({busy, data_resultRDY} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_accept_in_done: got busy=%b rdy=%b, want busy=1 rdy=0", busy, data_resultRDY);
      end
      repeat (33) @(negedge clock);
      checks++;
      if ({data_resultRDY, data_exception, data_result} !== {1'b1, 1'b0, 32'hFFFF_FFF2}) begin
         failures++;
         $display("FAIL b2b_second: got rdy=%b exc=%b result=%h, want rdy=1 exc=0 result=fffffff2",
                  data_resultRDY, data_exception, data_result);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_abort();
      int rdy_seen;
      issue(1'b0, 1'b1, 32'd1000, 32'd3);
      repeat (15) @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
         failures++;
         $display("FAIL abort_async: got result=%h exc=%b rdy=%b busy=%b, want all zero",
                  data_result, data_exception, data_resultRDY, busy);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      issue(1'b1, 1'b0, 32'd2, 32'd3);
      rdy_seen = 0;
      for (int k = 1; k <= 32; k++) begin
         if (data_resultRDY !== 1'b0 || busy !== 1'b1) rdy_seen++;
         @(negedge clock);
      end
      checks++;
      if (rdy_seen != 0) begin
         failures++;
         $display("FAIL abort_no_rdy: got %0d cycles with rdy high or busy low, want 0", rdy_seen);
      end
      @(negedge clock);
      checks++;
      if ({data_resultRDY, data_exception, data_result} !== {1'b1, 1'b0, 32'd6}) begin
         failures++;
         $display("FAIL abort_then_mul: got rdy=%b exc=%b result=%h, want rdy=1 exc=0 result=00000006",
                  data_resultRDY, data_exception, data_result);
      end
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_both();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: clock  input  1  single rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: data_operandA  input  32  signed multiplicand / dividend.
REQ-005 Port: data_operandB  input  32  signed multiplier / divisor.
REQ-006 Port: ctrl_MULT  input  1  start-multiply request, sampled on clock edge.
REQ-007 Port: ctrl_DIV  input  1  start-divide request, sampled on clock edge.
REQ-008 Port: data_result  output  32  signed result, held until the next accepted start.
REQ-009 Port: data_exception  output  1  overflow / divide-by-zero flag, valid with data_result.
REQ-010 Port: data_resultRDY  output  1  one-cycle result-valid pulse.
REQ-011 Port: busy  output  1  high while an operation is in progress.

Function
REQ-012 FSM states SHALL be IDLE, MUL, DIV, DONE; encoding is free.
REQ-013 A start SHALL be accepted only in IDLE or DONE; ctrl_MULT/ctrl_DIV in MUL or DIV SHALL be ignored, with no effect on operands or counter.
REQ-014 On acceptance, operands SHALL be latched internally; later input changes SHALL NOT affect the result.
REQ-015 If ctrl_MULT and ctrl_DIV are both high on an accepting edge, multiply SHALL win.
REQ-016 Multiply SHALL be iterative radix-2 Booth, one step per cycle, 32 steps, with a 6-bit step counter from 0 to 32.
REQ-017 Divide SHALL be iterative restoring divide on magnitudes, one quotient bit per cycle, 32 steps, with the sign fixed in the final step; the quotient truncates toward zero and the remainder is discarded.
REQ-018 Latency: start accepted at edge N -> data_resultRDY high for exactly the cycle after edge N+33, with state DONE; data_result and data_exception update on that same edge.
REQ-019 busy SHALL be high from the edge after acceptance through edge N+32 inclusive, and low in IDLE and DONE.
REQ-020 Multiply result: low 32 bits of the 64-bit signed product; data_exception=1 iff the product is outside [-2^31, 2^31-1].
REQ-021 Divide by zero (B=0): state goes directly to DONE on the edge after acceptance; result 0, exception 1, RDY pulse 1 cycle; no iterations run.
REQ-022 Divide overflow (A=0x80000000, B=0xFFFFFFFF): result 0x80000000, exception 1, normal 33-cycle latency.
REQ-023 DONE SHALL return to IDLE after one cycle unless a new start is accepted, which goes straight to MUL/DIV (back-to-back allowed).
REQ-024 data_resultRDY SHALL be low in every state except the first cycle of DONE.
REQ-025 All arithmetic SHALL be two's-complement; the internal multiply accumulator is 65 bits and the divide remainder register is 33 bits.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0, with no clock required.
REQ-027 Reset mid-operation SHALL abort the operation; no RDY pulse follows and the first start after release behaves as from power-up.
REQ-028 A start asserted on the first edge after reset_n release SHALL be accepted.

Verification
REQ-029 ctrl_MULT pulse, A=7, B=-6 -> 33 cycles later RDY=1 for 1 cycle, result 0xFFFFFFD6 (-42), exception 0.
REQ-030 ctrl_MULT, A=0x40000000, B=4 -> result 0x00000000, exception 1.
REQ-031 ctrl_DIV, A=-7, B=2 -> result 0xFFFFFFFD (-3), exception 0, 33-cycle latency; a ctrl_MULT pulse at cycle 10 is ignored (busy stays high).
REQ-032 ctrl_DIV, A=5, B=0 -> next cycle RDY=1, result 0, exception 1; ctrl_DIV A=0x80000000, B=-1 -> result 0x80000000, exception 1.
REQ-033 ctrl_MULT and ctrl_DIV together, A=3, B=3 -> result 9 (multiply).
REQ-034 Start a divide, drop reset_n at cycle 15 for 2 cycles -> outputs 0 immediately, no RDY; the next ctrl_MULT 2x3 -> result 6 after 33 cycles.
